// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared types and constants for the core-to-memory request path.
//   t_core2mem_req : request bundle driven by the core (70 bits)
//   t_mem2core_rsp : response bundle returned by memory (34 bits)
//   BE_*           : write byte-enable patterns accepted when the
//                    optional DMEM_BYTE_EN_CHK_EN check is built in
package dmem_responder_pkg;

    typedef struct packed {
        logic [31:0] wr_data;
        logic [31:0] address;
        logic        wr_en;
        logic        rd_en;
        logic [3:0]  byte_en;
    } t_core2mem_req;

    typedef struct packed {
        logic [31:0] rd_data;
        logic        rd_valid;
        logic        err;
    } t_mem2core_rsp;

    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    // Naturally aligned byte, halfword or word lane groups only.
    function automatic logic byte_en_legal(input logic [3:0] be);
        return (be == BE_BYTE0) || (be == BE_BYTE1) || (be == BE_BYTE2) ||
               (be == BE_BYTE3) || (be == BE_HALF0) || (be == BE_HALF1) ||
               (be == BE_WORD);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Core <-> data memory bus.
//   req      : t_core2mem_req, core -> memory
//   rd_data  : read word, memory -> core (0 unless rd_valid)
//   rd_valid : one-cycle pulse per accepted read
//   err      : one-cycle pulse in the response slot of a faulting request
//   Modports: master (core side), slave (memory side).
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    t_core2mem_req req;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic          err;

    modport master (output req, input  rd_data, rd_valid, err);
    modport slave  (input  req, output rd_data, rd_valid, err);

endinterface

// File: rtl/dmem_rd_pipe.sv
// dmem_rd_pipe
//   DEPTH-stage delay line for the {rd_data, rd_valid, err} response.
//   clk, rst_n : clock, asynchronous active-low reset (flushes all stages)
//   i_valid    : read accepted this cycle
//   i_data     : word sampled at the request edge
//   i_err      : request faulted
//   o_rsp      : response DEPTH cycles after the request edge
module dmem_rd_pipe
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [31:0]   i_data,
    input  logic          i_err,
    output t_mem2core_rsp o_rsp
);

    t_mem2core_rsp r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0].rd_data  <= i_valid ? i_data : '0;
            r_stage[0].rd_valid <= i_valid;
            r_stage[0].err      <= i_err;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_rsp = r_stage[DEPTH-1];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder: word-organised RAM with byte-enabled writes and
//   a RD_LATENCY-cycle fully pipelined read response.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset (response pipeline only; RAM kept)
//   bus   : dmem_responder_if.slave (req in; rd_data/rd_valid/err out)
//   Parameters: ADDR_W (word-index width), RD_LATENCY (1..4).
//   Optional macro DMEM_BYTE_EN_CHK_EN: reject writes whose non-zero
//   byte_en is not an aligned byte/halfword/word pattern (write dropped,
//   err pulsed).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_responder_if.slave bus
);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("dmem_responder: RD_LATENCY must be 1..4");
    end

    logic [31:0]       r_mem [2**ADDR_W];

    logic [ADDR_W-1:0] w_idx;
    logic              w_in_range;
    logic              w_be_bad;
    logic              w_wr_commit;
    logic              w_err;
    logic [31:0]       w_rd_word;
    logic              w_unused_addr_lsbs;
    t_mem2core_rsp     w_rsp;

    assign w_idx              = bus.req.address[ADDR_W+1:2];
    assign w_in_range         = (bus.req.address[31:ADDR_W+2] == '0);
    assign w_unused_addr_lsbs = ^bus.req.address[1:0];

`ifdef DMEM_BYTE_EN_CHK_EN
    assign w_be_bad = bus.req.wr_en && (bus.req.byte_en != '0) &&
                      !byte_en_legal(bus.req.byte_en);
`else
    assign w_be_bad = 1'b0;
`endif

    assign w_wr_commit = bus.req.wr_en && w_in_range && !w_be_bad;

    assign w_err = (bus.req.rd_en || bus.req.wr_en) &&
                   (!w_in_range || (bus.req.rd_en && bus.req.wr_en) || w_be_bad);

    // Sampled before the write of the same edge lands, so a colliding
    // read returns the pre-write word.
    assign w_rd_word = (bus.req.rd_en && w_in_range) ? r_mem[w_idx] : '0;

    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.req.byte_en[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.req.wr_data[8*i +: 8];
                end
            end
        end
    end

    dmem_rd_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (bus.req.rd_en),
        .i_data  (w_rd_word),
        .i_err   (w_err),
        .o_rsp   (w_rsp)
    );

    assign bus.rd_data  = w_rsp.rd_valid ? w_rsp.rd_data : '0;
    assign bus.rd_valid = w_rsp.rd_valid;
    assign bus.err      = w_rsp.err;

endmodule
